// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL,
// a burst of AUTO REFRESH commands and LOAD MODE REGISTER, then hands off.
module sdram_init_seq #(
  parameter int unsigned P_WAIT_CYCLES = 20000,
  parameter int unsigned P_TRP         = 2,
  parameter int unsigned P_TRFC        = 7,
  parameter int unsigned P_TMRD        = 2,
  parameter int unsigned P_REFRESH_NUM = 2,
  parameter logic [12:0] P_MODE_REG    = 13'h032
) (
  input  logic        s_clk,
  input  logic        s_rst,
  output logic        o_cke,
  output logic [3:0]  o_cmd,
  output logic [1:0]  o_ba,
  output logic [12:0] o_addr,
  output logic        o_init_done
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_REF, S_TRFC, S_LMR, S_TMRD, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ref_q, ref_d;
  logic [3:0]  cmd_d;
  logic [1:0]  ba_d;
  logic [12:0] addr_d;
  logic        done_d;

  // WAIT counts from the reset value 0, so it compares against the full count;
  // the gap states start at 0 on entry and compare against count-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    ref_d   = ref_q;
    unique case (state_q)
      S_WAIT: if (cnt_q == 16'(P_WAIT_CYCLES)) begin
        state_d = S_PRE;
        cnt_d   = '0;
      end
      S_PRE: begin
        state_d = S_TRP;
        cnt_d   = '0;
      end
      S_TRP: if (cnt_q == 16'(P_TRP - 1)) begin
        state_d = S_REF;
        cnt_d   = '0;
      end
      S_REF: begin
        ref_d   = ref_q + 4'd1;
        state_d = S_TRFC;
        cnt_d   = '0;
      end
      S_TRFC: if (cnt_q == 16'(P_TRFC - 1)) begin
        state_d = (ref_q < 4'(P_REFRESH_NUM)) ? S_REF : S_LMR;
        cnt_d   = '0;
      end
      S_LMR: begin
        state_d = S_TMRD;
        cnt_d   = '0;
      end
      S_TMRD: if (cnt_q == 16'(P_TMRD - 1)) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: cnt_d = cnt_q;
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    done_d = 1'b0;
    unique case (state_d)
      S_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = 13'h0400;
      end
      S_REF:   cmd_d = CMD_REF;
      S_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = P_MODE_REG;
      end
      S_DONE:  done_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      ref_q       <= '0;
      o_cke       <= 1'b0;
      o_cmd       <= CMD_NOP;
      o_ba        <= '0;
      o_addr      <= '0;
      o_init_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      o_cke       <= 1'b1;
      o_cmd       <= cmd_d;
      o_ba        <= ba_d;
      o_addr      <= addr_d;
      o_init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three instances with different parameter sets,
// compared cycle by cycle against a schedule computed from the command timing.
module tb_sdram_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = '0;

  logic        a_cke, b_cke, c_cke;
  logic [3:0]  a_cmd, b_cmd, c_cmd;
  logic [1:0]  a_ba, b_ba, c_ba;
  logic [12:0] a_addr, b_addr, c_addr;
  logic        a_done, b_done, c_done;

  sdram_init_seq #(.P_WAIT_CYCLES(10), .P_TRP(2), .P_TRFC(7), .P_TMRD(2),
                   .P_REFRESH_NUM(2), .P_MODE_REG(13'h032)) dut_a (
    .s_clk(clk), .s_rst(rst[0]), .o_cke(a_cke), .o_cmd(a_cmd), .o_ba(a_ba),
    .o_addr(a_addr), .o_init_done(a_done));

  sdram_init_seq #(.P_WAIT_CYCLES(1), .P_TRP(1), .P_TRFC(1), .P_TMRD(1),
                   .P_REFRESH_NUM(1), .P_MODE_REG(13'h032)) dut_b (
    .s_clk(clk), .s_rst(rst[1]), .o_cke(b_cke), .o_cmd(b_cmd), .o_ba(b_ba),
    .o_addr(b_addr), .o_init_done(b_done));

  sdram_init_seq dut_c (
    .s_clk(clk), .s_rst(rst[2]), .o_cke(c_cke), .o_cmd(c_cmd), .o_ba(c_ba),
    .o_addr(c_addr), .o_init_done(c_done));

  int unsigned pw[3]   = '{10, 1, 20000};
  int unsigned ptrp[3] = '{2, 1, 2};
  int unsigned ptrfc[3]= '{7, 1, 7};
  int unsigned ptmrd[3]= '{2, 1, 2};
  int unsigned prn[3]  = '{2, 1, 2};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          sel   = 0;

  // {cke, cmd[3:0], ba[1:0], addr[12:0], init_done}
  logic [20:0] obs;
  always_comb begin
    obs = '0;
    case (sel)
      0:       obs = {a_cke, a_cmd, a_ba, a_addr, a_done};
      1:       obs = {b_cke, b_cmd, b_ba, b_addr, b_done};
      default: obs = {c_cke, c_cmd, c_ba, c_addr, c_done};
    endcase
  end

  function automatic int unsigned done_cycle(int s);
    return pw[s] + 1 + ptrp[s] + prn[s] * (1 + ptrfc[s]) + 1 + ptmrd[s] + 1;
  endfunction

  // Expected outputs at cycle k after reset release (k=0 means held in reset).
  function automatic logic [20:0] model(int s, int unsigned k);
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
    int unsigned lmr;
    cmd  = 4'b0111;
    addr = '0;
    done = 1'b0;
    if (k == 0) return {1'b0, 4'b0111, 2'b00, 13'h0, 1'b0};
    lmr = pw[s] + 1 + ptrp[s] + prn[s] * (1 + ptrfc[s]) + 1;
    if (k == pw[s] + 1) begin
      cmd  = 4'b0010;
      addr = 13'h0400;
    end
    for (int unsigned r = 0; r < prn[s]; r++)
      if (k == pw[s] + 2 + ptrp[s] + r * (1 + ptrfc[s])) cmd = 4'b0001;
    if (k == lmr) begin
      cmd  = 4'b0000;
      addr = 13'h032;
    end
    if (k > lmr + ptmrd[s]) done = 1'b1;
    return {1'b1, cmd, 2'b00, addr, done};
  endfunction

  task automatic test_reset();
    rst = '1;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        sel = s;
        #1;
        n_vec++;
        if (obs !== model(s, 0)) begin
          n_err++;
          $display("FAIL reset_hold dut=%0d cyc=%0d got=%h exp=%h", s, c, obs, model(s, 0));
        end
      end
    end
  endtask

  task automatic test_sequence();
    sel = 0;
    @(negedge clk);
    rst[0] = 1'b0;
    for (int unsigned k = 1; k <= done_cycle(0) + 100; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== model(0, k)) begin
        n_err++;
        $display("FAIL sequence cyc=%0d got=%h exp=%h", k, obs, model(0, k));
      end
    end
  endtask

  task automatic test_mid_reset(int unsigned at_cyc, string tag);
    sel = 0;
    @(negedge clk);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    for (int unsigned k = 1; k <= at_cyc; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== model(0, k)) begin
        n_err++;
        $display("FAIL %s pre cyc=%0d got=%h exp=%h", tag, k, obs, model(0, k));
      end
    end
    #2 rst[0] = 1'b1;
    #1;
    n_vec++;
    if (obs !== model(0, 0)) begin
      n_err++;
      $display("FAIL %s async got=%h exp=%h", tag, obs, model(0, 0));
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    for (int unsigned k = 1; k <= done_cycle(0) + 10; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== model(0, k)) begin
        n_err++;
        $display("FAIL %s post cyc=%0d got=%h exp=%h", tag, k, obs, model(0, k));
      end
    end
  endtask

  task automatic test_min_params();
    sel = 1;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int unsigned k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== model(1, k)) begin
        n_err++;
        $display("FAIL min_params cyc=%0d got=%h exp=%h", k, obs, model(1, k));
      end
    end
  endtask

  task automatic test_random_reset();
    int          s;
    int unsigned stop;
    for (int unsigned it = 0; it < 6; it++) begin
      s   = int'($urandom_range(0, 1));
      sel = s;
      @(negedge clk);
      rst[s] = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst[s] = 1'b0;
      stop = $urandom_range(1, done_cycle(s) + 10);
      for (int unsigned k = 1; k <= stop; k++) begin
        @(negedge clk);
        n_vec++;
        if (obs !== model(s, k)) begin
          n_err++;
          $display("FAIL rand_pre dut=%0d cyc=%0d got=%h exp=%h", s, k, obs, model(s, k));
        end
      end
      #($urandom_range(1, 4)) rst[s] = 1'b1;
      #0.5;
      n_vec++;
      if (obs !== model(s, 0)) begin
        n_err++;
        $display("FAIL rand_async dut=%0d got=%h exp=%h", s, obs, model(s, 0));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst[s] = 1'b0;
      for (int unsigned k = 1; k <= done_cycle(s) + 5; k++) begin
        @(negedge clk);
        n_vec++;
        if (obs !== model(s, k)) begin
          n_err++;
          $display("FAIL rand_post dut=%0d cyc=%0d got=%h exp=%h", s, k, obs, model(s, k));
        end
      end
    end
  endtask

  task automatic test_defaults();
    int unsigned first_done;
    int unsigned n_cmd;
    first_done = 0;
    n_cmd      = 0;
    sel        = 2;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int unsigned k = 1; k <= 25000; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== model(2, k)) begin
        n_err++;
        $display("FAIL defaults cyc=%0d got=%h exp=%h", k, obs, model(2, k));
      end
      if (obs[19:16] !== 4'b0111) n_cmd++;
      if (obs[0] === 1'b1 && first_done == 0) first_done = k;
      if (first_done != 0 && k >= first_done + 5) break;
    end
    n_vec++;
    if (first_done != 20023) begin
      n_err++;
      $display("FAIL defaults_done_cycle got=%0d exp=%0d", first_done, 20023);
    end
    n_vec++;
    if (n_cmd != 4) begin
      n_err++;
      $display("FAIL defaults_cmd_count got=%0d exp=%0d", n_cmd, 4);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequence();
    test_mid_reset(18, "mid_reset_trfc");
    test_mid_reset(50, "reset_in_done");
    test_min_params();
    test_random_reset();
    test_defaults();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- SDRAM power-up initialisation sequencer for the MT48LC32M16 (SM48LC32M16M) controller.
- Sits directly downstream of the power-on reset generator; the top level drives s_rst from the inverted generator output.
- After reset it waits the power-up delay, then issues PRECHARGE ALL, P_REFRESH_NUM AUTO REFRESH commands and LOAD MODE REGISTER, each with the required NOP gap.
- It then raises o_init_done, which hands the command bus to the main controller.

Parameters:
- P_WAIT_CYCLES, 20000: NOP cycles after reset before the first command (200 us at 100 MHz). Range 1..65535.
- P_TRP, 2: NOP cycles after PRECHARGE. Must be ≥1.
- P_TRFC, 7: NOP cycles after each AUTO REFRESH. Must be ≥1.
- P_TMRD, 2: NOP cycles after LOAD MODE REGISTER. Must be ≥1.
- P_REFRESH_NUM, 2: number of AUTO REFRESH commands. Range 1..15.
- P_MODE_REG, 13'h032: value driven on o_addr during LOAD MODE REGISTER (CL=3, sequential, BL=4).

Ports:
- s_clk  input  1  system clock; all logic on rising edge.
- s_rst  input  1  asynchronous, active-high reset.
- o_cke  output  1  SDRAM clock enable.
- o_cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
- o_ba  output  2  bank address.
- o_addr  output  13  address bus.
- o_init_done  output  1  high once the sequence is complete.

Behaviour:
- Interface: one clock, s_clk. Reset s_rst is asynchronous and active-high.
- Outputs: all registered; there is no combinational path from any input to any output.
- Command encodings:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
  - LOAD MODE = 4'b0000
- Reset values, asserted asynchronously while s_rst=1:
  - o_cke=0, o_cmd=NOP, o_ba=0, o_addr=0, o_init_done=0
  - state=WAIT, all counters=0
- Cycle numbering: cycle k is the output value after the k-th rising edge of s_clk with s_rst=0.
- o_cke: equals 1 from cycle 1 onward.
- FSM states: WAIT, PRE, TRP, REF, TRFC, LMR, TMRD, DONE.
  - WAIT: o_cmd=NOP for cycles 1..P_WAIT_CYCLES. A 16-bit counter ends the state after exactly P_WAIT_CYCLES cycles.
  - PRE: one cycle of PRECHARGE with o_addr[10]=1 (all banks) and the other address bits 0.
  - TRP: exactly P_TRP NOP cycles.
  - REF: one cycle of AUTO REFRESH. A 4-bit refresh counter increments on each REF cycle.
  - TRFC: exactly P_TRFC NOP cycles. Then go to REF if refresh count < P_REFRESH_NUM, otherwise to LMR.
  - LMR: one cycle of LOAD MODE with o_addr=P_MODE_REG and o_ba=0.
  - TMRD: exactly P_TMRD NOP cycles.
  - DONE: o_init_done=1 from the cycle after the last TMRD NOP. o_cmd=NOP, o_addr=0, o_ba=0. Holds indefinitely; only reset leaves DONE.
- Total cycles to o_init_done: P_WAIT_CYCLES + 1 + P_TRP + P_REFRESH_NUM*(1+P_TRFC) + 1 + P_TMRD + 1.
- Command width: every non-NOP command lasts exactly one cycle. Outside PRE and LMR, o_addr=0 and o_ba=0.
- Reset mid-sequence: any s_rst pulse, including a pulse in DONE, immediately restores the reset values. The sequence restarts from WAIT with the full P_WAIT_CYCLES delay.
- Counter reload: the delay counter is cleared on every state transition, so the next delay count is correct with no extra cycle.

Test Plan:
1. Parameters P_WAIT_CYCLES=10, P_TRP=2, P_TRFC=7, P_TMRD=2, P_REFRESH_NUM=2. Release reset and check:
   - cycles 1-10 NOP
   - cycle 11 PRECHARGE with addr[10]=1
   - cycles 12-13 NOP
   - cycle 14 AUTO REFRESH; cycles 15-21 NOP
   - cycle 22 AUTO REFRESH; cycles 23-29 NOP
   - cycle 30 LOAD MODE with addr=13'h032, ba=0
   - cycles 31-32 NOP
   - o_init_done=1 from cycle 33 and stays 1 for ≥100 further cycles, with cmd=NOP
2. Same parameters, assert s_rst asynchronously mid-cycle at cycle 18 (inside TRFC). Check:
   - outputs go to reset values before the next edge
   - after release, PRECHARGE reappears exactly at cycle 11
3. Same parameters, assert s_rst in DONE at cycle 50. Check:
   - o_init_done drops at once
   - the full sequence repeats, with o_init_done rising at cycle 33 after release
4. P_REFRESH_NUM=1, P_TRP=1, P_TRFC=1, P_TMRD=1, P_WAIT_CYCLES=1. Check:
   - cycle 1 NOP
   - cycle 2 PRE, cycle 3 NOP
   - cycle 4 REF, cycle 5 NOP
   - cycle 6 LMR, cycle 7 NOP
   - o_init_done=1 at cycle 8
5. Hold s_rst=1 for 20 cycles. Check o_cke=0, o_cmd=4'b0111 and o_init_done=0 throughout.
6. Default parameters. Check o_init_done rises at cycle 20000+1+2+2*8+1+2+1 = 20023, and exactly 4 non-NOP commands are issued in total.
